// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin bus/RAM arbiter: FSM encodings,
// requester indices and default sizing.
package bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_GRANT = 2'd1;
  localparam logic [1:0] ARB_TURN  = 2'd2;

  localparam int REQ_CU           = 0;
  localparam int DEFAULT_N_REQ    = 4;
  localparam int DEFAULT_MAX_HOLD = 16;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  first;

  // rot[gi] = req[(gi + ptr) mod N_REQ], built as a mux of constant taps.
  genvar gi, gj;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [N_REQ-1:0] hit;
      for (gj = 0; gj < N_REQ; gj++) begin : g_src
        assign hit[gj] = req[gj] & (ptr == ID_W'((gj - gi + N_REQ) % N_REQ));
      end
      assign rot[gi] = |hit;
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    first = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        first = ID_W'(k);
      end
    end
  end

  always_comb begin
    if (({1'b0, first} + {1'b0, ptr}) >= (ID_W + 1)'(N_REQ))
      idx = first + ptr - ID_W'(N_REQ);
    else
      idx = first + ptr;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared tristate bus, with a dead turnaround
// cycle between owners. Define BUS_ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEFAULT_N_REQ,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             bus_busy,
  output logic             cu_stall,
  output logic             timeout
);

  logic [1:0]       state_reg, state_next;
  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [N_REQ-1:0] grant_next;
  logic [ID_W-1:0]  grant_id_next;
  logic             busy_next;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             expire;

  rr_priority_pick #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_reg),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    grant_next    = grant;
    grant_id_next = grant_id;
    busy_next     = bus_busy;
    case (state_reg)
      ARB_GRANT: begin
        if (!req[grant_id] || expire) begin
          grant_next = '0;
          busy_next  = 1'b0;
          ptr_next   = ID_W'(wrap_inc(32'(grant_id), N_REQ));
          state_next = ARB_TURN;
        end
      end
      // IDLE and TURN arbitrate identically; TURN simply follows a release.
      default: begin
        grant_next = '0;
        busy_next  = 1'b0;
        state_next = ARB_IDLE;
        if (pick_found) begin
          grant_next[pick_idx] = 1'b1;
          grant_id_next        = pick_idx;
          busy_next            = 1'b1;
          state_next           = ARB_GRANT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ARB_IDLE;
      ptr_reg   <= '0;
      grant     <= '0;
      grant_id  <= '0;
      bus_busy  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant     <= grant_next;
      grant_id  <= grant_id_next;
      bus_busy  <= busy_next;
    end
  end

  assign cu_stall = req[REQ_CU] & ~grant[REQ_CU];

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              timeout_reg;

  assign expire = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

  // Counts GRANT cycles; zero on the first cycle of each tenure.
  always_comb begin
    hold_cnt_next = hold_cnt_reg + 1'b1;
    if (state_next == ARB_GRANT && state_reg != ARB_GRANT)
      hold_cnt_next = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      timeout_reg  <= (state_reg == ARB_GRANT) & expire & req[grant_id];
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_max_hold;

  assign expire          = 1'b0;
  assign timeout         = 1'b0;
  assign unused_max_hold = ^MAX_HOLD;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the driver updates an owner/pointer model
// and queues expected outputs; the monitor pops and compares every cycle.
module tb_bus_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;
  localparam int ID_W     = 2;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  grant;
  logic [ID_W-1:0] grant_id;
  logic          bus_busy;
  logic          cu_stall;
  logic          timeout;

  bus_arbiter #(
    .N_REQ   (N),
    .MAX_HOLD(MAX_HOLD),
    .ID_W    (ID_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .grant   (grant),
    .grant_id(grant_id),
    .bus_busy(bus_busy),
    .cu_stall(cu_stall),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    logic         busy;
    int           id;
    logic         tmo;
    logic         in_reset;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  // Reference model: who owns the bus, where the scan starts, tenure length.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_ten   = 0;
  logic m_tmo   = 1'b0;

  task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, c, got, want);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic rn);
    int c;
    if (!rn) begin
      m_owner = -1; m_ptr = 0; m_ten = 0; m_tmo = 1'b0;
    end else if (m_owner >= 0) begin
      if (!r[m_owner] || (TMO_EN && m_ten >= MAX_HOLD)) begin
        m_tmo   = r[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_ten   = 0;
      end else begin
        m_ten++;
        m_tmo = 1'b0;
      end
    end else begin
      m_tmo = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (m_owner < 0 && r[c]) m_owner = c;
      end
      if (m_owner >= 0) m_ten = 1;
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rn);
    exp_t e;
    @(negedge clk);
    req     = r;
    reset_n = rn;
    cyc++;
    model_edge(r, rn);
    e.grant = '0;
    if (m_owner >= 0) e.grant[m_owner] = 1'b1;
    e.busy     = (m_owner >= 0);
    e.id       = (m_owner >= 0) ? m_owner : 0;
    e.tmo      = m_tmo;
    e.in_reset = !rn;
    e.cyc      = cyc;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant",    e.cyc, 32'(grant),    32'(e.grant));
        check("bus_busy", e.cyc, 32'(bus_busy), 32'(e.busy));
        check("timeout",  e.cyc, 32'(timeout),  32'(e.tmo));
        check("cu_stall", e.cyc, 32'(cu_stall), 32'(req[0] & ~e.grant[0]));
        if (e.busy || e.in_reset)
          check("grant_id", e.cyc, 32'(grant_id), e.id);
        if (e.busy && !prev_busy)
          $display("[TB] cycle %0d: bus granted to req %0d", e.cyc, e.id);
        prev_busy = e.busy;
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] r;
    logic         rn;

    repeat (4) step(4'b1111, 1'b0);

    repeat (5) step(4'b0100, 1'b1);
    repeat (3) step(4'b0000, 1'b1);

    // Every owner gives up the bus after two granted cycles.
    for (int i = 0; i < 30; i++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_ten >= 2) r[m_owner] = 1'b0;
      step(r, 1'b1);
    end
    repeat (2) step(4'b0000, 1'b1);

    // CU waits behind req[1].
    repeat (2) step(4'b0010, 1'b1);
    for (int i = 0; i < 10; i++) begin
      r = 4'b0011;
      if (m_owner == 1 && m_ten >= 3) r = 4'b0001;
      if (m_owner == 0 && m_ten >= 3) r = 4'b0000;
      step(r, 1'b1);
    end
    repeat (2) step(4'b0000, 1'b1);

    // Long hold: revoked after MAX_HOLD with the timeout build, unbounded otherwise.
    repeat (40) step(4'b1000, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    // Reset in the middle of a tenure, then the scan restarts at req 0.
    repeat (3) step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0000, 1'b1);
    repeat (4) step(4'b0011, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    for (int i = 0; i < 600; i++) begin
      r = N'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 15) != 0) r[m_owner] = 1'b1;
      rn = ($urandom_range(0, 99) != 0);
      step(r, rn);
    end
    repeat (3) step(4'b0000, 1'b1);

    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
